gate_truth_table_checker: RTL
=============================

// Module: gate_truth_table_checker
// PURPOSE
//   Drives an external 2-input gate-under-test (GUT) through all four input
//   combinations, samples its output and assembles the 4-bit truth table.
//   Decodes the truth table into a gate identity code; flags unstable outputs.
//   Sits beside the gate library as the self-test and identification front end.
// PARAMETERS
//   SETTLE_CYCLES   2  cycles to wait after each new combination before sampling (>=0)
//   STABLE_SAMPLES  3  consecutive samples of gut_y that must agree per combination (>=1)
// PORTS
//   clk          in   1  single clock, all state on rising edge
//   rst          in   1  synchronous reset, active-high
//   start        in   1  begin a check run; sampled only when busy=0
//   busy         out  1  high from the cycle after start is accepted until done
//   done         out  1  one-cycle pulse when results become valid
//   gut_a        out  1  GUT input a (registered)
//   gut_b        out  1  GUT input b (registered)
//   gut_y        in   1  GUT output
//   truth_table  out  4  bit i = gut_y for {a,b} = i (i = 0..3)
//   gate_code    out  3  0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 UNKNOWN
//   unstable     out  1  a combination saw disagreeing samples during the last run
// BEHAVIOUR
//   Reset: busy=0, done=0, gut_a=0, gut_b=0, truth_table=0, gate_code=7, unstable=0; FSM->IDLE.
//   FSM: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE for next idx | FINISH) -> IDLE.
//   - IDLE: start=1 at edge T accepts run; idx<=0, unstable<=0, truth_table<=0.
//   - DRIVE: 1 cycle; {gut_a,gut_b}<=idx[1:0]; busy=1.
//   - SETTLE: SETTLE_CYCLES cycles, skipped when 0; gut_y ignored.
//   - SAMPLE: STABLE_SAMPLES cycles; first sample is reference; any later sample
//     differing sets unstable (sticky for run); truth_table[idx] <= reference.
//   - idx 3 done -> FINISH: gate_code updated, done=1 for exactly 1 cycle, busy=0 same cycle.
//   Per-combination cost: 1 + SETTLE_CYCLES + STABLE_SAMPLES cycles.
//   done asserts at T + 4*(1+SETTLE_CYCLES+STABLE_SAMPLES) + 1.
//   Decode (truth_table[3:0]): 1000 AND, 1110 OR, 0111 NAND, 0001 NOR,
//     0110 XOR, 1001 XNOR, 0011 NOT(a); anything else -> 7; unstable=1 forces 7.
//   truth_table/gate_code/unstable held from done until next accepted start;
//     cleared to reset values in the accept cycle.
//   start while busy=1 ignored (not queued); start held high re-triggers only
//     when back in IDLE (earliest the cycle after done).
//   gut_a/gut_b hold last combination (1,1) after FINISH until next run.
//   rst mid-run: next cycle identical to reset state; partial results discarded.
//   idx is 2 bits; no wrap past 3 — FINISH entered instead.
// TESTING
//   GUT = a&b, SETTLE=2, STABLE=3, start at T -> done at T+25, tt=4'b1000, code=0, unstable=0.
//   GUT = a^b and a~^b separately -> tt=4'b0110 code=4; tt=4'b1001 code=5; done one cycle wide.
//   GUT = ~a (b ignored) -> tt=4'b0011, code=6; GUT tied 0 -> tt=4'b0000, code=7.
//   GUT = a|b, toggle gut_y on 2nd sample of idx 2 -> unstable=1, code=7, tt[2]=1st sample.
//   rst pulsed while idx=2 -> next cycle busy=0, gut_a=gut_b=0, code=7; new start completes normally.
//   start pulsed again mid-run and held high through done -> single run, next run starts at done+1.

Source files
------------

// File: rtl/gate_truth_table_checker_if.sv
// gate_truth_table_checker_if
//   Groups the run handshake, the gate-under-test (GUT) drive and sense lines
//   and the result bus of gate_truth_table_checker.
//   slave  : the checker. It receives start and gut_y. It drives busy, done,
//            gut_a, gut_b, truth_table, gate_code and unstable.
//   master : the environment, i.e. whoever requests runs and owns the GUT.
interface gate_truth_table_checker_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       gut_a;
  logic       gut_b;
  logic       gut_y;
  logic [3:0] truth_table;
  logic [2:0] gate_code;
  logic       unstable;

  modport master (
    output start, gut_y,
    input  busy, done, gut_a, gut_b, truth_table, gate_code, unstable
  );

  modport slave (
    input  start, gut_y,
    output busy, done, gut_a, gut_b, truth_table, gate_code, unstable
  );
endinterface

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
//   Steps an external 2-input gate through {a,b} = 0..3. After each new input
//   pair it waits SETTLE_CYCLES cycles, then takes STABLE_SAMPLES samples of
//   gut_y. It builds the 4-bit truth table from those samples and decodes the
//   table into a gate identity code. Any disagreement between the samples of
//   one combination marks the run unstable, and an unstable run reports the
//   gate as UNKNOWN.
// Ports
//   clk          : single clock; all state changes on the rising edge
//   rst          : synchronous reset, active-high
//   bus.start    : requests a run; looked at only while idle
//   bus.busy     : high from the cycle after acceptance until done
//   bus.done     : one-cycle pulse when the results become valid
//   bus.gut_a/b  : registered GUT inputs
//   bus.gut_y    : GUT output
//   bus.truth_table : bit i = gut_y for {a,b} = i
//   bus.gate_code   : 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 UNKNOWN
//   bus.unstable    : samples of some combination disagreed during the last run
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int STABLE_SAMPLES = 3
) (
  input logic                        clk,
  input logic                        rst,
  gate_truth_table_checker_if.slave  bus
);

  localparam logic [2:0] CODE_UNKNOWN = 3'd7;

  // One counter serves both SETTLE and SAMPLE, so size it for the longer of the two.
  localparam int MAX_CNT = (SETTLE_CYCLES > STABLE_SAMPLES) ? SETTLE_CYCLES : STABLE_SAMPLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(STABLE_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t        state_reg;
  logic [1:0]    idx_reg;
  logic [CW-1:0] cnt_reg;
  logic          ref_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          gut_a_reg;
  logic          gut_b_reg;
  logic [3:0]    truth_table_reg;
  logic [2:0]    gate_code_reg;
  logic          unstable_reg;

  logic          sample_first;
  logic          sample_last;
  logic          sample_val;
  logic          mismatch;
  logic [3:0]    truth_table_next;

  function automatic logic [2:0] decode_gate(input logic [3:0] tt, input logic unst);
    logic [2:0] code;
    case (tt)
      4'b1000: code = 3'd0;  // AND
      4'b1110: code = 3'd1;  // OR
      4'b0111: code = 3'd2;  // NAND
      4'b0001: code = 3'd3;  // NOR
      4'b0110: code = 3'd4;  // XOR
      4'b1001: code = 3'd5;  // XNOR
      4'b0011: code = 3'd6;  // NOT(a)
      default: code = CODE_UNKNOWN;
    endcase
    // A table built from disagreeing samples cannot be trusted.
    if (unst) code = CODE_UNKNOWN;
    return code;
  endfunction

  always_comb begin
    sample_first = (cnt_reg == '0);
    sample_last  = (state_reg == S_SAMPLE) && (cnt_reg == SAMPLE_LAST);
    // The first sample is the reference. With STABLE_SAMPLES=1 the first
    // sample is also the last one, so it is taken straight from gut_y.
    sample_val   = sample_first ? bus.gut_y : ref_reg;
    mismatch     = (state_reg == S_SAMPLE) && !sample_first && (bus.gut_y != ref_reg);
  end

  // Only the bit selected by idx takes the reference, and only on the last
  // sample of its combination.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tt_bit
      assign truth_table_next[gi] = (sample_last && (idx_reg == 2'(gi)))
                                    ? sample_val : truth_table_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      ref_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      gut_a_reg       <= 1'b0;
      gut_b_reg       <= 1'b0;
      truth_table_reg <= '0;
      gate_code_reg   <= CODE_UNKNOWN;
      unstable_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            idx_reg         <= '0;
            unstable_reg    <= 1'b0;
            truth_table_reg <= '0;
            gate_code_reg   <= CODE_UNKNOWN;
            busy_reg        <= 1'b1;
            state_reg       <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          gut_a_reg <= idx_reg[1];
          gut_b_reg <= idx_reg[0];
          cnt_reg   <= '0;
          state_reg <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
        end

        S_SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg   <= '0;
            state_reg <= S_SAMPLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        S_SAMPLE: begin
          if (sample_first) ref_reg <= bus.gut_y;
          if (mismatch) unstable_reg <= 1'b1;
          truth_table_reg <= truth_table_next;
          if (sample_last) begin
            // idx stays at 3 instead of wrapping; the run ends here.
            if (idx_reg == 2'd3) begin
              state_reg <= S_FINISH;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= S_DRIVE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        S_FINISH: begin
          gate_code_reg <= decode_gate(truth_table_reg, unstable_reg);
          done_reg      <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.gut_a       = gut_a_reg;
  assign bus.gut_b       = gut_b_reg;
  assign bus.truth_table = truth_table_reg;
  assign bus.gate_code   = gate_code_reg;
  assign bus.unstable    = unstable_reg;

endmodule
